// File: rtl/sdad_acq_sequencer.sv
// Sigma-delta ADC conversion sequencer: paces the modulator, drives the feedback bit and
// decimates ones-counts into samples. Optional macro SDAD_SEQ_OVERRUN_EN keeps a pending sample.
module sdad_acq_sequencer #(
    parameter int OSR_LOG2 = 8,
    parameter int DIV      = 4,
    parameter int SETTLE_N = 16,
    parameter int SAMPLE_W = OSR_LOG2 + 1
) (
    input  logic                sysClk,
    input  logic                sysRst,
    input  logic                start,
    input  logic                continuous,
    input  logic                bitIn,
    output logic                fbOut,
    output logic [SAMPLE_W-1:0] dataOut,
    output logic                dataValid,
    input  logic                dataReady,
    output logic                busy,
    output logic                overrun
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SET_W = $clog2(SETTLE_N + 1);

    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
    localparam logic [SET_W-1:0]    SET_LAST = SET_W'(SETTLE_N - 1);
    localparam logic [SET_W-1:0]    SET_ONE  = SET_W'(1);
    localparam logic [OSR_LOG2-1:0] INT_LAST = '1;
    localparam logic [OSR_LOG2-1:0] INT_ONE  = OSR_LOG2'(1);

    typedef enum logic [1:0] {IDLE, SETTLE, INTEGRATE} state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [SET_W-1:0]    settle_cnt;
    logic [OSR_LOG2-1:0] int_cnt;
    logic [SAMPLE_W-1:0] acc_p0;
    logic [SAMPLE_W-1:0] res_p1;
    logic                vld_p1;
    logic                strobe;

    assign strobe = (div_cnt == DIV_LAST);

    // acc holds at most 2**OSR_LOG2 in SAMPLE_W bits, so this add never wraps
    function automatic logic [SAMPLE_W-1:0] acc_step(input logic [SAMPLE_W-1:0] acc,
                                                     input logic b);
        return acc + SAMPLE_W'(b);
    endfunction

`ifndef SDAD_SEQ_OVERRUN_EN
    assign overrun = 1'b0;
`endif

    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            settle_cnt <= '0;
            int_cnt    <= '0;
            acc_p0     <= '0;
            res_p1     <= '0;
            vld_p1     <= 1'b0;
            fbOut      <= 1'b0;
            dataOut    <= '0;
            dataValid  <= 1'b0;
            busy       <= 1'b0;
`ifdef SDAD_SEQ_OVERRUN_EN
            overrun    <= 1'b0;
`endif
        end else begin
            // Stage p0: strobe pacing, settle discard and ones accumulation
            vld_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    fbOut      <= 1'b0;
                    div_cnt    <= '0;
                    settle_cnt <= '0;
                    int_cnt    <= '0;
                    acc_p0     <= '0;
                    if (start) begin
                        state <= SETTLE;
                        busy  <= 1'b1;
`ifdef SDAD_SEQ_OVERRUN_EN
                        overrun <= 1'b0;
`endif
                    end
                end
                SETTLE: begin
                    div_cnt <= strobe ? '0 : div_cnt + DIV_ONE;
                    if (strobe) begin
                        fbOut <= bitIn;
                        if (settle_cnt == SET_LAST) begin
                            settle_cnt <= '0;
                            int_cnt    <= '0;
                            acc_p0     <= '0;
                            state      <= INTEGRATE;
                        end else begin
                            settle_cnt <= settle_cnt + SET_ONE;
                        end
                    end
                end
                INTEGRATE: begin
                    div_cnt <= strobe ? '0 : div_cnt + DIV_ONE;
                    if (strobe) begin
                        fbOut   <= bitIn;
                        int_cnt <= int_cnt + INT_ONE;
                        if (int_cnt == INT_LAST) begin
                            res_p1 <= acc_step(acc_p0, bitIn);
                            vld_p1 <= 1'b1;
                            acc_p0 <= '0;
                            if (!continuous) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            acc_p0 <= acc_step(acc_p0, bitIn);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Stage p1: publish the finished sample through the valid/ready hand-off
            if (vld_p1) begin
`ifdef SDAD_SEQ_OVERRUN_EN
                if (dataValid && !dataReady) begin
                    overrun <= 1'b1;
                end else begin
                    dataOut   <= res_p1;
                    dataValid <= 1'b1;
                end
`else
                dataOut   <= res_p1;
                dataValid <= 1'b1;
`endif
            end else if (dataValid && dataReady) begin
                dataValid <= 1'b0;
            end
        end
    end

endmodule
